// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IF (fetch) and ME (load/store) stages,
// holding each grant for WAIT_STATES extra cycles. Build option: MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            me_req,
  input  logic            me_we,
  input  logic [2:0]      me_ctrl,
  input  logic [XLEN-1:0] me_addr,
  input  logic [XLEN-1:0] me_wdata,
  output logic [XLEN-1:0] me_rdata,
  output logic            me_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic [2:0]      mem_ctrl,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            if_stall,
  output logic            me_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_ACC = 2'b01,
    ME_ACC = 2'b10
  } state_t;

  localparam logic [3:0] WS_C = WAIT_STATES[3:0];

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      wcnt_q;
  logic [3:0]      wcnt_d;
  logic            last_me_q;
  logic            last_me_d;
  logic [XLEN-1:0] if_hold_q;
  logic [XLEN-1:0] if_hold_d;
  logic [XLEN-1:0] me_hold_q;
  logic [XLEN-1:0] me_hold_d;
  logic            if_done_s;
  logic            me_done_s;
  logic            pick_me_s;

  // Tie-break when both ports request in IDLE: true selects ME.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign pick_me_s = ~last_me_q;
`else
  assign pick_me_s = 1'b1;
`endif

  assign if_done_s = (state_q == IF_ACC) && (wcnt_q == WS_C);
  assign me_done_s = (state_q == ME_ACC) && (wcnt_q == WS_C);

  // State, wait counter, grant history and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      last_me_q <= 1'b1;
      if_hold_q <= {XLEN{1'b0}};
      me_hold_q <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      last_me_q <= last_me_d;
      if_hold_q <= if_hold_d;
      me_hold_q <= me_hold_d;
    end
  end

  // Next-state, wait counting and read-data capture on the closing edge
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    last_me_d = last_me_q;
    if_hold_d = if_hold_q;
    me_hold_d = me_hold_q;
    case (state_q)
      IDLE: begin
        if (me_req && (!if_req || pick_me_s)) begin
          state_d   = ME_ACC;
          wcnt_d    = 4'd0;
          last_me_d = 1'b1;
        end else if (if_req) begin
          state_d   = IF_ACC;
          wcnt_d    = 4'd0;
          last_me_d = 1'b0;
        end else begin
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end
      end
      IF_ACC: begin
        if (if_done_s) begin
          if_hold_d = mem_rdata;
          wcnt_d    = 4'd0;
          // The finishing port's req is stale here, so only the other port can follow directly.
          if (me_req) begin
            state_d   = ME_ACC;
            last_me_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ME_ACC: begin
        if (me_done_s) begin
          me_hold_d = mem_rdata;
          wcnt_d    = 4'd0;
          if (if_req) begin
            state_d   = IF_ACC;
            last_me_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Memory-side drive: idle bus is all zeros, fetches are always word reads
  always_comb begin
    mem_addr  = {XLEN{1'b0}};
    mem_wdata = {XLEN{1'b0}};
    mem_we    = 1'b0;
    mem_ctrl  = 3'b000;
    case (state_q)
      IF_ACC: begin
        mem_addr = if_addr;
        mem_ctrl = 3'b010;
      end
      ME_ACC: begin
        mem_addr  = me_addr;
        mem_wdata = me_wdata;
        mem_we    = me_we;
        mem_ctrl  = me_ctrl;
      end
      default: begin
        mem_addr  = {XLEN{1'b0}};
        mem_wdata = {XLEN{1'b0}};
        mem_we    = 1'b0;
        mem_ctrl  = 3'b000;
      end
    endcase
  end

  assign if_ready = if_done_s;
  assign me_ready = me_done_s;
  assign if_rdata = if_done_s ? mem_rdata : if_hold_q;
  assign me_rdata = me_done_s ? mem_rdata : me_hold_q;
  assign if_stall = if_req & ~if_done_s;
  assign me_stall = me_req & ~me_done_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: four instances (WAIT_STATES 1,0,3,15) checked against
// a transaction-level model, plus a vector table and directed corner-case sequences.
module tb_mem_arbiter;

  localparam int NI = 4;
  localparam int unsigned WS_TAB [NI] = '{32'd1, 32'd0, 32'd3, 32'd15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a       [NI];
  logic        if_req_a    [NI];
  logic [31:0] if_addr_a   [NI];
  logic [31:0] if_rdata_a  [NI];
  logic        if_ready_a  [NI];
  logic        me_req_a    [NI];
  logic        me_we_a     [NI];
  logic [2:0]  me_ctrl_a   [NI];
  logic [31:0] me_addr_a   [NI];
  logic [31:0] me_wdata_a  [NI];
  logic [31:0] me_rdata_a  [NI];
  logic        me_ready_a  [NI];
  logic [31:0] mem_addr_a  [NI];
  logic [31:0] mem_wdata_a [NI];
  logic        mem_we_a    [NI];
  logic [2:0]  mem_ctrl_a  [NI];
  logic [31:0] mem_rdata_a [NI];
  logic        if_stall_a  [NI];
  logic        me_stall_a  [NI];
  logic        mem_clr;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_dflt(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [31:0] mem [256];

    mem_arbiter #(.WAIT_STATES(WS_TAB[g]), .XLEN(32)) u_dut (
      .clk      (clk),
      .reset    (rst_a[g]),
      .if_req   (if_req_a[g]),
      .if_addr  (if_addr_a[g]),
      .if_rdata (if_rdata_a[g]),
      .if_ready (if_ready_a[g]),
      .me_req   (me_req_a[g]),
      .me_we    (me_we_a[g]),
      .me_ctrl  (me_ctrl_a[g]),
      .me_addr  (me_addr_a[g]),
      .me_wdata (me_wdata_a[g]),
      .me_rdata (me_rdata_a[g]),
      .me_ready (me_ready_a[g]),
      .mem_addr (mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]),
      .mem_we   (mem_we_a[g]),
      .mem_ctrl (mem_ctrl_a[g]),
      .mem_rdata(mem_rdata_a[g]),
      .if_stall (if_stall_a[g]),
      .me_stall (me_stall_a[g])
    );

    // Simple memory: combinational read, write on the clock edge
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) mem[i] <= mem_dflt(32'(i << 2));
      end else if (mem_we_a[g]) begin
        mem[mem_addr_a[g][9:2]] <= mem_wdata_a[g];
      end
    end
    assign mem_rdata_a[g] = mem[mem_addr_a[g][9:2]];
  end

  // ---------------- reference model (grant owner + cycles left) ----------------
  int          m_gnt  [NI];   // 0 none, 1 IF, 2 ME
  int          m_rem  [NI];   // cycles left before the completion cycle
  int          m_last [NI];
  logic [31:0] m_hif  [NI];
  logic [31:0] m_hme  [NI];
  logic [31:0] m_mem  [NI][256];
  logic        e_ir   [NI];
  logic        e_mr   [NI];
  logic [31:0] e_rd   [NI];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, g, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int g);
    m_gnt[g]  = 0;
    m_rem[g]  = 0;
    m_last[g] = 2;
    m_hif[g]  = 32'd0;
    m_hme[g]  = 32'd0;
  endtask

  task automatic check_cycle(input int g);
    logic [31:0] ea, ewd;
    logic        ewe;
    logic [2:0]  ectl;
    ea = 32'd0; ewd = 32'd0; ewe = 1'b0; ectl = 3'b000;
    if (m_gnt[g] == 1) begin
      ea = if_addr_a[g]; ectl = 3'b010;
    end else if (m_gnt[g] == 2) begin
      ea = me_addr_a[g]; ewd = me_wdata_a[g]; ewe = me_we_a[g]; ectl = me_ctrl_a[g];
    end
    e_ir[g] = (m_gnt[g] == 1) && (m_rem[g] == 0);
    e_mr[g] = (m_gnt[g] == 2) && (m_rem[g] == 0);
    e_rd[g] = m_mem[g][ea[9:2]];
    chk("if_ready", g, 32'(if_ready_a[g]), 32'(e_ir[g]));
    chk("me_ready", g, 32'(me_ready_a[g]), 32'(e_mr[g]));
    chk("mem_addr", g, mem_addr_a[g], ea);
    chk("mem_wdata", g, mem_wdata_a[g], ewd);
    chk("mem_we", g, 32'(mem_we_a[g]), 32'(ewe));
    chk("mem_ctrl", g, 32'(mem_ctrl_a[g]), 32'(ectl));
    chk("if_rdata", g, if_rdata_a[g], e_ir[g] ? e_rd[g] : m_hif[g]);
    chk("me_rdata", g, me_rdata_a[g], e_mr[g] ? e_rd[g] : m_hme[g]);
    chk("if_stall", g, 32'(if_stall_a[g]), 32'(if_req_a[g] & ~e_ir[g]));
    chk("me_stall", g, 32'(me_stall_a[g]), 32'(me_req_a[g] & ~e_mr[g]));
  endtask

  task automatic model_edge(input int g);
    int nxt;
    nxt = 0;
    if (!rst_a[g]) begin
      model_reset(g);
      return;
    end
    if (m_gnt[g] == 2 && me_we_a[g]) m_mem[g][me_addr_a[g][9:2]] = me_wdata_a[g];
    if (m_gnt[g] != 0 && m_rem[g] > 0) begin
      m_rem[g]--;
    end else begin
      if (m_gnt[g] == 1) begin
        m_hif[g] = e_rd[g];
        if (me_req_a[g]) nxt = 2;
      end else if (m_gnt[g] == 2) begin
        m_hme[g] = e_rd[g];
        if (if_req_a[g]) nxt = 1;
      end else if (if_req_a[g] && me_req_a[g]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        nxt = (m_last[g] == 2) ? 1 : 2;
`else
        nxt = 2;
`endif
      end else if (if_req_a[g]) begin
        nxt = 1;
      end else if (me_req_a[g]) begin
        nxt = 2;
      end
      m_gnt[g] = nxt;
      if (nxt != 0) begin
        m_rem[g]  = int'(WS_TAB[g]);
        m_last[g] = nxt;
      end
    end
  endtask

  task automatic chk_neg();
    @(negedge clk);
    for (int g = 0; g < NI; g++) check_cycle(g);
  endtask

  task automatic edge_pos();
    @(posedge clk);
    for (int g = 0; g < NI; g++) model_edge(g);
    #1;
  endtask

  task automatic fetch_lat(input int g, input logic [31:0] addr, output int lat, output int stalls);
    logic done;
    done = 1'b0; lat = 0; stalls = 0;
    if_req_a[g] = 1'b1;
    if_addr_a[g] = addr;
    for (int c = 0; c < 40 && !done; c++) begin
      chk_neg();
      lat++;
      if (if_stall_a[g]) stalls++;
      if (if_ready_a[g]) done = 1'b1;
      edge_pos();
    end
    if_req_a[g] = 1'b0;
    chk("fetch_done", g, 32'(done), 32'd1);
  endtask

  // ---------------- vector table for the WAIT_STATES=0 instance ----------------
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mwe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        x_ir;
    logic        x_mr;
    logic        x_we;
    logic [31:0] x_ma;
    logic        x_is;
    logic        x_ms;
    logic        chk_rd;
    logic [31:0] x_mrd;
  } vec_t;

  vec_t tv [8];

  initial begin
    automatic int lat, stl;
    automatic logic [31:0] r;
    tv[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
    tv[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0};
    tv[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[4] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tv[5] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0,       1'b1, 1'b0, 1'b0, 32'h20,  1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    tv[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
`else
    tv[5] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0,       1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[6] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,   32'h0,       1'b1, 1'b0, 1'b0, 32'h20,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
`endif
    tv[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'hDEADBEEF};

    mem_clr = 1'b1;
    for (int g = 0; g < NI; g++) begin
      rst_a[g] = 1'b0; if_req_a[g] = 1'b0; if_addr_a[g] = 32'd0;
      me_req_a[g] = 1'b0; me_we_a[g] = 1'b0; me_ctrl_a[g] = 3'b010;
      me_addr_a[g] = 32'd0; me_wdata_a[g] = 32'd0;
      e_ir[g] = 1'b0; e_mr[g] = 1'b0; e_rd[g] = 32'd0;
      model_reset(g);
      for (int i = 0; i < 256; i++) m_mem[g][i] = mem_dflt(32'(i << 2));
    end
    repeat (3) begin
      chk_neg();
      edge_pos();
    end
    for (int g = 0; g < NI; g++) rst_a[g] = 1'b1;
    mem_clr = 1'b0;
    chk_neg();
    for (int g = 0; g < NI; g++) begin
      chk("rst_if_ready", g, 32'(if_ready_a[g]), 32'd0);
      chk("rst_mem_addr", g, mem_addr_a[g], 32'd0);
      chk("rst_me_rdata", g, me_rdata_a[g], 32'd0);
    end
    edge_pos();

    // Store then load, simultaneous requests (WAIT_STATES=0)
    for (int i = 0; i < 8; i++) begin
      if_req_a[1] = tv[i].ir;   if_addr_a[1] = tv[i].ia;
      me_req_a[1] = tv[i].mr;   me_we_a[1] = tv[i].mwe;
      me_addr_a[1] = tv[i].ma;  me_wdata_a[1] = tv[i].mwd;
      chk_neg();
      chk("tv_if_ready", i, 32'(if_ready_a[1]), 32'(tv[i].x_ir));
      chk("tv_me_ready", i, 32'(me_ready_a[1]), 32'(tv[i].x_mr));
      chk("tv_mem_we", i, 32'(mem_we_a[1]), 32'(tv[i].x_we));
      chk("tv_mem_addr", i, mem_addr_a[1], tv[i].x_ma);
      chk("tv_if_stall", i, 32'(if_stall_a[1]), 32'(tv[i].x_is));
      chk("tv_me_stall", i, 32'(me_stall_a[1]), 32'(tv[i].x_ms));
      if (tv[i].chk_rd) chk("tv_me_rdata", i, me_rdata_a[1], tv[i].x_mrd);
      edge_pos();
    end

    // Single fetch with WAIT_STATES=1 and with WAIT_STATES=15
    fetch_lat(0, 32'h10, lat, stl);
    chk("fetch_ws1_latency", 0, 32'(lat), 32'd3);
    chk("fetch_ws1_stall_cycles", 0, 32'(stl), 32'd2);
    repeat (2) begin
      chk_neg();
      edge_pos();
    end
    chk("fetch_ws1_rdata_held", 0, if_rdata_a[0], 32'h0050_0093);
    fetch_lat(3, 32'h44, lat, stl);
    chk("fetch_ws15_latency", 3, 32'(lat), 32'd17);
    chk("fetch_ws15_stall_cycles", 3, 32'(stl), 32'd16);

    // Reset in the wcnt=2 cycle of a load (WAIT_STATES=3), after a load filled the holding register
    me_req_a[2] = 1'b1; me_we_a[2] = 1'b0; me_addr_a[2] = 32'h40; me_ctrl_a[2] = 3'b010;
    repeat (8) begin
      chk_neg();
      edge_pos();
    end
    chk("pre_reset_hold", 2, me_rdata_a[2], mem_dflt(32'h40));
    #2;
    rst_a[2] = 1'b0;
    me_req_a[2] = 1'b0;
    model_reset(2);
    #1;
    chk("mid_rst_mem_addr", 2, mem_addr_a[2], 32'd0);
    chk("mid_rst_mem_ctrl", 2, 32'(mem_ctrl_a[2]), 32'd0);
    chk("mid_rst_me_ready", 2, 32'(me_ready_a[2]), 32'd0);
    chk("mid_rst_me_rdata", 2, me_rdata_a[2], 32'd0);
    chk_neg();
    edge_pos();
    rst_a[2] = 1'b1;
    repeat (5) begin
      chk_neg();
      edge_pos();
    end

    // Randomized traffic on all instances, honouring the hold-until-ready protocol
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < NI; g++) begin
        if (if_req_a[g]) begin
          if (e_ir[g]) begin
            if ($urandom_range(1, 0) == 1) if_req_a[g] = 1'b0;
            else begin
              r = $urandom_range(255, 0);
              if_addr_a[g] = r << 2;
            end
          end
        end else if ($urandom_range(3, 0) == 0) begin
          r = $urandom_range(255, 0);
          if_req_a[g] = 1'b1;
          if_addr_a[g] = r << 2;
        end
        if (me_req_a[g] && e_mr[g] && $urandom_range(1, 0) == 1) begin
          me_req_a[g] = 1'b0;
        end else if ((me_req_a[g] && e_mr[g]) || (!me_req_a[g] && $urandom_range(2, 0) == 0)) begin
          r = $urandom_range(255, 0);
          me_req_a[g] = 1'b1;
          me_addr_a[g] = r << 2;
          me_we_a[g] = 1'($urandom_range(1, 0));
          me_ctrl_a[g] = 3'($urandom_range(7, 0));
          me_wdata_a[g] = $urandom;
        end
      end
      chk_neg();
      edge_pos();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port data/instruction memory between the IF stage (instruction fetch) and the ME stage (load/store) of the 5-stage RISC-V pipeline. A registered FSM grants one requester at a time and holds the access for a configurable number of wait states. It returns read data with a one-cycle `ready` pulse and drives stall signals that freeze the pipeline registers while an access is outstanding.

## Interface
- `WAIT_STATES`, 1: extra cycles each memory access is held beyond the first. Legal range 0..15.
- `XLEN`, 32: address and data width.

- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch access pending; held with `if_addr` stable until `if_ready`.
- `if_addr`  in  XLEN  fetch byte address.
- `if_rdata`  out  XLEN  fetched instruction.
- `if_ready`  out  1  one-cycle completion pulse for a fetch.
- `me_req`  in  1  load/store access pending; held with address, data and controls stable until `me_ready`.
- `me_we`  in  1  1 = store, 0 = load.
- `me_ctrl`  in  3  access size/sign (funct3 encoding, same as `dm_ctrl`).
- `me_addr`  in  XLEN  data byte address.
- `me_wdata`  in  XLEN  store data.
- `me_rdata`  out  XLEN  load data.
- `me_ready`  out  1  one-cycle completion pulse for a load/store.
- `mem_addr`  out  XLEN  to memory.
- `mem_wdata`  out  XLEN  to memory.
- `mem_we`  out  1  to memory.
- `mem_ctrl`  out  3  to memory.
- `mem_rdata`  in  XLEN  from memory, combinational read.
- `if_stall`  out  1  `if_req & ~if_ready`; freezes PC and `if_de`.
- `me_stall`  out  1  `me_req & ~me_ready`; freezes all pipeline registers.

## Operation
- FSM states:
  - IDLE: no grant.
  - IF_ACC: fetch granted.
  - ME_ACC: load/store granted.
- Wait counter `wcnt` (4 bits):
  - cleared on entry to IF_ACC/ME_ACC.
  - increments each cycle in an ACC state.
  - The completion cycle is `wcnt == WAIT_STATES`.
- IDLE transitions:
  - Neither request: stay in IDLE.
  - One request: go to that requester's ACC state.
  - Both requests: priority rule (see Configuration).
- ACC state, non-completion cycle: stay in the state and increment `wcnt`.
- ACC state, completion cycle:
  - Assert that port's `ready`.
  - The completing port's `req` is treated as stale and ignored.
  - If the other port is requesting, go directly to its ACC state; otherwise go to IDLE.
- Memory drive:
  - IDLE: `mem_addr`, `mem_wdata`, `mem_we`, `mem_ctrl` are all 0.
  - IF_ACC: `mem_addr=if_addr`, `mem_ctrl=3'b010` (word), `mem_we=0`.
  - ME_ACC: `me_*` fields passed through; `mem_we=me_we` on every cycle of the access.
- Read data:
  - In the completion cycle, `*_rdata` equals `mem_rdata` (bypass).
  - On the closing clock edge, `mem_rdata` is loaded into that port's holding register.
  - In all other cycles, `*_rdata` outputs the holding register.
  - For a store completion, `me_rdata` is updated with `mem_rdata` all the same; the value is don't-care to the pipeline.
- `last_grant` flop: records the port granted most recently.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state IDLE, `wcnt=0`, `last_grant=ME`, both holding registers 0.
  - All outputs 0; stalls become 0 once requests are low.
- Reset mid-access aborts the access immediately. No `ready` pulse is issued and no holding register is updated.
- Latency, request rising in IDLE at edge k:
  - grant from cycle k+1.
  - `ready` in cycle k+1+WAIT_STATES.
  - Total WAIT_STATES+2 cycles.
- Back-to-back requests from the same port incur one IDLE bubble between accesses.
- Requests from alternating ports incur no bubble.
- `ready` and `stall` are combinational from state, `wcnt` and `req`. They never glitch high outside the completion cycle.
- Dropping `req` mid-access is illegal. The access still completes and `ready` still pulses.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both ports request in IDLE, grant the port opposite to `last_grant`.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, ME always wins over IF. `last_grant` is still maintained.

## Test plan
- Single fetch, WAIT_STATES=1:
  - Stimulus: `if_req=1`, `if_addr=0x10`, memory returns 0x00500093.
  - Response: `if_ready` pulses exactly 3 cycles after request; `if_rdata=0x00500093` held afterwards; `if_stall` high for 2 cycles.
- Store, then load, WAIT_STATES=0:
  - Stimulus: store word 0xDEADBEEF to 0x100, then load from 0x100.
  - Response: `mem_we=1` for one cycle only; load returns 0xDEADBEEF; `me_ready` pulses 2 cycles after each request.
- Simultaneous requests, macro undefined:
  - Stimulus: `if_req` and `me_req` both asserted in IDLE.
  - Response: ME granted first; IF granted in the cycle immediately after `me_ready`, with no bubble.
- Simultaneous requests, macro defined:
  - Stimulus: both ports request continuously for 4 accesses.
  - Response: grants alternate ME, IF, ME, IF.
- Reset mid-access, WAIT_STATES=3:
  - Stimulus: `reset` driven low during `wcnt=2` of an ME load.
  - Response: immediately state IDLE, `mem_*` = 0, no `me_ready`, `me_rdata=0`.
- WAIT_STATES=15:
  - Stimulus: single fetch.
  - Response: `if_ready` 17 cycles after request; `wcnt` does not wrap early.
